mem_arbiter: RTL
================

# mem_arbiter

Shares the single external memory bus between instruction fetch (driven by the PC register's `pc` and `ce`) and the MEM-stage load/store unit. It sequences one bus transaction at a time, holds the requesting stage via stall requests until data returns, and discards fetches killed by a branch flush. A watchdog bounds every transaction. The stall requests feed the pipeline control block that builds the `stall` vector.

## Interface

- `BUS_TIMEOUT`, default 255: cycles `bus_req` may stay high without `bus_ack` before forced completion. Legal range 1..65535.
- `clk`  in  1  pipeline clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low; when 0, all state and outputs are cleared immediately.
- `if_req`  in  1  fetch request (tied to `ce`).
- `if_addr`  in  32  fetch address (`pc`).
- `if_rdata`  out  32  fetched instruction; valid while `if_ready` = 1.
- `if_ready`  out  1  one-cycle completion pulse for the fetch.
- `flush`  in  1  branch taken; kills any pending or just-completed fetch.
- `mem_req`  in  1  load/store request.
- `mem_we`  in  1  1 = store.
- `mem_addr`  in  32  data address.
- `mem_wdata`  in  32  store data.
- `mem_sel`  in  4  byte enables.
- `mem_rdata`  out  32  load data; valid while `mem_ready` = 1.
- `mem_ready`  out  1  one-cycle completion pulse for the data access.
- `bus_req`  out  1  transaction active; held until ack or timeout.
- `bus_we`, `bus_addr`, `bus_wdata`, `bus_sel`  out  1/32/32/4  registered transaction fields, stable while `bus_req` = 1.
- `bus_rdata`  in  32  slave read data; sampled at the ack edge.
- `bus_ack`  in  1  slave completion; only meaningful while `bus_req` = 1.
- `bus_err`  out  1  one-cycle pulse on timeout.
- `stall_req_if`  out  1  combinational: `if_req & ~if_ready`.
- `stall_req_mem`  out  1  combinational: `mem_req & ~mem_ready`.

## Operation

- States: IDLE, IF_WAIT, MEM_WAIT, DONE.
- IDLE:
  - If `mem_req` is high, go to MEM_WAIT. Otherwise, if `if_req` is high and `flush` is low, go to IF_WAIT.
  - At the grant edge, latch the fields into the `bus_*` registers and set `bus_req` = 1.
  - Fetches are read-only: `bus_we` = 0, `bus_sel` = 4'hF.
  - MEM has fixed priority. This does not starve fetch, because the MEM stage stalls the pipeline behind it.
- IF_WAIT / MEM_WAIT, on the edge where `bus_ack` = 1:
  - `bus_req` <= 0.
  - The requester's `*_rdata` <= `bus_rdata`. Stores also return `bus_rdata`, and the requester ignores it.
  - The requester's `*_ready` <= 1.
  - Go to DONE.
- Timeout: a watchdog counter clears at grant and increments each WAIT cycle without ack. On the edge where the count reaches `BUS_TIMEOUT`:
  - Complete as if acked, with `*_rdata` <= 0.
  - `bus_err` <= 1 for one cycle.
  - `bus_req` <= 0.
- DONE: clear the ready pulse, then always go to IDLE. No grant is issued in DONE, so the requester has one edge to advance or drop its request.
- Flush:
  - A flush during IF_WAIT sets the `kill` flag. The bus transaction still runs to ack or timeout, but `if_ready` is suppressed and `if_rdata` is not updated.
  - A flush in the same cycle as the completion edge also suppresses `if_ready`.
  - `kill` clears on entry to DONE.
  - A flush in IDLE blocks the fetch grant in that cycle only.
  - Flush has no effect on MEM transactions.
- Dropped request: if the requester drops its request mid-transaction, the transaction completes normally. The ready pulse is still produced, and the requester ignores it.
- Ack outside WAIT states is ignored.

## Timing

- Reset values:
  - `bus_req`, `bus_we`, `if_ready`, `mem_ready`, `bus_err` = 0.
  - `bus_addr`, `bus_wdata`, `if_rdata`, `mem_rdata` = 0.
  - `bus_sel` = 0.
  - State = IDLE, watchdog count = 0, `kill` = 0.
- Reset asserted mid-transaction drops `bus_req` asynchronously; no ready pulse is produced. After release, the first grant occurs at the first edge with a pending request.
- Zero-wait slave (ack combinational in the first `bus_req` cycle), request sampled at edge E0:
  - `bus_req` is high during cycle E0–E1.
  - Ready is high during cycle E1–E2.
  - State is IDLE after E2.
  - A back-to-back request is granted at E3.
  - Minimum occupancy is 3 cycles per access.
- Each extra wait cycle of the slave adds 1 cycle.
- `*_ready`, `bus_err` and the `bus_*` outputs are registered. The stall requests are the only combinational outputs.

## Test plan

- Single fetch: `if_req` = 1, `if_addr` = 0x100, slave acks in the same cycle with 0x24020005 -> `bus_addr` = 0x100, `bus_sel` = 0xF, `if_ready` is high exactly one cycle with `if_rdata` = 0x24020005, and `stall_req_if` is high until then.
- Contention: `if_req` and `mem_req` rise in the same cycle with a store (addr 0x2000, wdata 0xDEADBEEF, sel 0x3) -> the store is issued first with `bus_we` = 1, then the fetch is granted 3 cycles later.
- Wait states: slave delays ack by 4 cycles on a load returning 0x55AA -> `bus_req` is high 5 cycles, `mem_rdata` = 0x55AA, and `stall_req_mem` is high for 6 cycles.
- Flush: flush pulses 1 cycle during IF_WAIT -> the transaction completes on the bus, no `if_ready` is produced, and `if_rdata` keeps its previous value.
- Timeout: `BUS_TIMEOUT` = 8, slave never acks -> `bus_req` drops after 8 WAIT cycles, `bus_err` pulses once, `mem_ready` = 1 with `mem_rdata` = 0.
- Reset mid-op: `reset` = 0 during MEM_WAIT -> `bus_req` = 0 without waiting for a clock edge, all outputs are 0, and a fresh request after release is granted normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single external memory bus between instruction fetch and the
// MEM-stage load/store unit. It runs one bus transaction at a time, holds the
// requesting stage with a stall request until its data returns, and discards
// fetches that a branch flush has killed. A watchdog forces every transaction
// to complete within BUS_TIMEOUT wait cycles.
//
// Parameters
//   BUS_TIMEOUT   wait cycles without bus_ack before forced completion (1..65535)
//
// Ports
//   clk, reset            pipeline clock, asynchronous active-low reset
//   if_req/if_addr        fetch request and address (pc)
//   if_rdata/if_ready     fetched instruction and one-cycle completion pulse
//   flush                 branch taken: kills a pending or completing fetch
//   mem_req/mem_we/...    load/store request, address, store data, byte enables
//   mem_rdata/mem_ready   load data and one-cycle completion pulse
//   bus_*                 registered bus transaction fields, bus_rdata/bus_ack in
//   bus_err               one-cycle pulse on watchdog timeout
//   stall_req_if/_mem     combinational stall requests to pipeline control
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int unsigned BUS_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ready,
   input  logic        flush,
   input  logic        mem_req,
   input  logic        mem_we,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_sel,
   output logic [31:0] mem_rdata,
   output logic        mem_ready,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_sel,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack,
   output logic        bus_err,
   output logic        stall_req_if,
   output logic        stall_req_mem
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_IF_WAIT  = 2'd1,
      S_MEM_WAIT = 2'd2,
      S_DONE     = 2'd3
   } state_e;

   // The count value at which the next unacknowledged wait edge times out.
   localparam logic [15:0] WD_LAST = 16'(BUS_TIMEOUT - 1);

   state_e      state_q, state_d;
   logic        bus_req_q, bus_req_d;
   logic        bus_we_q, bus_we_d;
   logic [31:0] bus_addr_q, bus_addr_d;
   logic [31:0] bus_wdata_q, bus_wdata_d;
   logic [3:0]  bus_sel_q, bus_sel_d;
   logic [31:0] if_rdata_q, if_rdata_d;
   logic [31:0] mem_rdata_q, mem_rdata_d;
   logic        if_ready_q, if_ready_d;
   logic        mem_ready_q, mem_ready_d;
   logic        bus_err_q, bus_err_d;
   logic [15:0] wd_cnt_q, wd_cnt_d;
   logic        kill_q, kill_d;

   logic        in_wait;
   logic        ack_hit;
   logic        timeout_hit;
   logic        complete;
   logic        grant_mem;
   logic        grant_if;
   logic [31:0] ret_data;

   assign in_wait     = (state_q == S_IF_WAIT) || (state_q == S_MEM_WAIT);
   assign ack_hit     = in_wait & bus_ack;
   // An ack on the same edge as the timeout wins: the slave did return data.
   assign timeout_hit = in_wait & ~bus_ack & (wd_cnt_q == WD_LAST);
   assign complete    = ack_hit | timeout_hit;
   assign ret_data    = ack_hit ? bus_rdata : 32'h0;

   // MEM has fixed priority; a flush only blocks a fetch grant in this cycle.
   assign grant_mem   = (state_q == S_IDLE) & mem_req;
   assign grant_if    = (state_q == S_IDLE) & ~mem_req & if_req & ~flush;

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= 32'h0;
         bus_wdata_q <= 32'h0;
         bus_sel_q   <= 4'h0;
         if_rdata_q  <= 32'h0;
         mem_rdata_q <= 32'h0;
         if_ready_q  <= 1'b0;
         mem_ready_q <= 1'b0;
         bus_err_q   <= 1'b0;
         wd_cnt_q    <= 16'h0;
         kill_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         bus_sel_q   <= bus_sel_d;
         if_rdata_q  <= if_rdata_d;
         mem_rdata_q <= mem_rdata_d;
         if_ready_q  <= if_ready_d;
         mem_ready_q <= mem_ready_d;
         bus_err_q   <= bus_err_d;
         wd_cnt_q    <= wd_cnt_d;
         kill_q      <= kill_d;
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (grant_mem)     state_d = S_MEM_WAIT;
            else if (grant_if) state_d = S_IF_WAIT;
         end
         S_IF_WAIT, S_MEM_WAIT: begin
            if (complete) state_d = S_DONE;
         end
         // DONE never grants, giving the requester one edge to move on.
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ----------------------------------------------------------- outputs/datapath
   always_comb begin
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      bus_sel_d   = bus_sel_q;
      if_rdata_d  = if_rdata_q;
      mem_rdata_d = mem_rdata_q;
      if_ready_d  = 1'b0;
      mem_ready_d = 1'b0;
      bus_err_d   = 1'b0;
      wd_cnt_d    = wd_cnt_q;
      kill_d      = kill_q;

      case (state_q)
         S_IDLE: begin
            if (grant_mem) begin
               bus_req_d   = 1'b1;
               bus_we_d    = mem_we;
               bus_addr_d  = mem_addr;
               bus_wdata_d = mem_wdata;
               bus_sel_d   = mem_sel;
               wd_cnt_d    = 16'h0;
            end else if (grant_if) begin
               // Fetches are always full-word reads.
               bus_req_d   = 1'b1;
               bus_we_d    = 1'b0;
               bus_addr_d  = if_addr;
               bus_wdata_d = 32'h0;
               bus_sel_d   = 4'hF;
               wd_cnt_d    = 16'h0;
               kill_d      = 1'b0;
            end
         end
         S_IF_WAIT: begin
            if (complete) begin
               bus_req_d = 1'b0;
               bus_err_d = timeout_hit;
               kill_d    = 1'b0;
               // A flush now or earlier in this transaction discards the data.
               if (!(kill_q | flush)) begin
                  if_rdata_d = ret_data;
                  if_ready_d = 1'b1;
               end
            end else begin
               wd_cnt_d = wd_cnt_q + 16'd1;
               if (flush) kill_d = 1'b1;
            end
         end
         S_MEM_WAIT: begin
            if (complete) begin
               bus_req_d   = 1'b0;
               bus_err_d   = timeout_hit;
               kill_d      = 1'b0;
               mem_rdata_d = ret_data;
               mem_ready_d = 1'b1;
            end else begin
               wd_cnt_d = wd_cnt_q + 16'd1;
            end
         end
         default: ;
      endcase
   end

   assign bus_req       = bus_req_q;
   assign bus_we        = bus_we_q;
   assign bus_addr      = bus_addr_q;
   assign bus_wdata     = bus_wdata_q;
   assign bus_sel       = bus_sel_q;
   assign if_rdata      = if_rdata_q;
   assign mem_rdata     = mem_rdata_q;
   assign if_ready      = if_ready_q;
   assign mem_ready     = mem_ready_q;
   assign bus_err       = bus_err_q;
   assign stall_req_if  = if_req & ~if_ready_q;
   assign stall_req_mem = mem_req & ~mem_ready_q;

endmodule
